// File: rtl/gcd_disp_pkg.sv
// gcd_disp_pkg: shared states, segment codes and BCD helper for the GCD result display
package gcd_disp_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int NUM_DIGITS = 3;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: BCD nibble to active-low {g,f,e,d,c,b,a} segments, blank above 9
module bcd_to_seg7
  import gcd_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    case (nib)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/gcd_result_display.sv
// gcd_result_display: captures a GCD result, converts it to BCD by double-dabble, scans a 4-digit 7-seg display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module gcd_result_display
  import gcd_disp_pkg::*;
#(
  parameter int REFRESH_CNT = 100000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  din,
  output logic        busy,
  output logic        valid,
  output logic [11:0] bcd,
  output logic [3:0]  an,
  output logic [6:0]  seg
);
  localparam int CW = $clog2(REFRESH_CNT);
  state_t state, state_n;
  logic [2:0] step, step_n;
  logic [19:0] sh, sh_n, adj;
  logic [11:0] bcd_n;
  logic valid_n;
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic [3:0] nib;
  logic [6:0] seg_dec;
  logic blank, wrap;
  assign busy = state == SHIFT;
  assign adj = {add3(sh[19:16]), add3(sh[15:12]), add3(sh[11:8]), sh[7:0]};
  always_comb begin
    state_n = state;
    step_n = step;
    sh_n = sh;
    bcd_n = bcd;
    valid_n = valid;
    if (state == IDLE) begin
      if (load) begin
        sh_n = {12'h000, din};
        step_n = '0;
        state_n = SHIFT;
      end
    end else begin
      sh_n = {adj[18:0], 1'b0};
      step_n = step + 3'd1;
      if (step == 3'd7) begin
        bcd_n = sh_n[19:8];
        valid_n = 1'b1;
        state_n = IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      step <= '0;
      sh <= '0;
      bcd <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      step <= step_n;
      sh <= sh_n;
      bcd <= bcd_n;
      valid <= valid_n;
    end
  end
  assign wrap = cnt == CW'(REFRESH_CNT - 1);
  assign nib = idx == 2'd0 ? bcd[3:0] : idx == 2'd1 ? bcd[7:4] : bcd[11:8];
`ifdef LEADING_ZERO_BLANK_EN
  assign blank = idx == 2'd3 || (idx == 2'd2 && bcd[11:8] == 4'd0) || (idx == 2'd1 && bcd[11:4] == 8'd0);
`else
  assign blank = idx == 2'd3;
`endif
  bcd_to_seg7 u_dec (.nib(nib), .seg(seg_dec));
  // an/seg follow idx by one cycle; digits stay dark until a result exists
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
      idx <= '0;
      an <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      idx <= wrap ? idx + 2'd1 : idx;
      an <= valid ? ~(4'b0001 << idx) : 4'b1111;
      seg <= (!valid || blank) ? SEG_BLANK : seg_dec;
    end
  end
endmodule

// File: tb/tb_gcd_result_display.sv
// tb_gcd_result_display: directed checks of conversion, load dropping, async clear and display scan
module tb_gcd_result_display;
  logic clk = 0, clr = 0, load = 0;
  logic [7:0] din = 0;
  logic busy, valid;
  logic [11:0] bcd;
  logic [3:0] an;
  logic [6:0] seg;
  int total = 0, bad = 0;

  gcd_result_display #(.REFRESH_CNT(4)) dut (
    .clk(clk), .clr(clr), .load(load), .din(din),
    .busy(busy), .valid(valid), .bcd(bcd), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic convert(input logic [7:0] v, input logic [11:0] exp);
    @(negedge clk);
    din = v;
    load = 1;
    @(negedge clk);
    load = 0;
    chk("busy_start", busy, 1);
    repeat (7) @(negedge clk);
    chk("busy_e7", busy, 1);
    @(negedge clk);
    chk("busy_done", busy, 0);
    chk("valid_done", valid, 1);
    chk("bcd", bcd, exp);
  endtask

  logic [3:0] prev, an_exp [4];
  logic [6:0] seg_exp [4];
  bit found;

  initial begin
    an_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`ifdef LEADING_ZERO_BLANK_EN
    seg_exp = '{7'b0100100, 7'b0010010, 7'b1111111, 7'b1111111};
`else
    seg_exp = '{7'b0100100, 7'b0010010, 7'b1000000, 7'b1111111};
`endif
    #2 clr = 1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 7'b1111111);
    @(negedge clk);
    clr = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("dark", an, 4'b1111);
    end
    convert(8'd4, 12'h004);
    convert(8'd228, 12'h228);
    convert(8'd255, 12'h255);
    convert(8'd0, 12'h000);
    @(negedge clk);
    din = 8'd52;
    load = 1;
    @(negedge clk);
    load = 0;
    @(negedge clk);
    din = 8'd139;
    load = 1;
    @(negedge clk);
    load = 0;
    repeat (5) @(negedge clk);
    chk("drop_busy", busy, 1);
    chk("drop_hold", bcd, 12'h000);
    @(negedge clk);
    chk("drop_busy_end", busy, 0);
    chk("drop_bcd", bcd, 12'h052);
    @(negedge clk);
    chk("drop_idle", busy, 0);
    prev = an;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an == 4'b1110 && prev != 4'b1110) found = 1;
      prev = an;
    end
    chk("scan_sync", found, 1);
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 4; c++) begin
        chk("scan_an", an, an_exp[d]);
        chk("scan_seg", seg, seg_exp[d]);
        @(negedge clk);
      end
    chk("scan_wrap", an, 4'b1110);
    din = 8'd228;
    load = 1;
    @(negedge clk);
    load = 0;
    repeat (3) @(negedge clk);
    #2 clr = 1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_bcd", bcd, 0);
    chk("abort_an", an, 4'b1111);
    @(negedge clk);
    clr = 0;
    repeat (10) @(negedge clk);
    chk("abort_stay_valid", valid, 0);
    chk("abort_stay_bcd", bcd, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
